// File: rtl/power_iter_ctrl.sv
// Power-iteration sequencer: feeds the estimate to an external mat-vec unit, hands the
// product to an external normaliser and repeats until max |new - old| <= tol or the cap.
module power_iter_ctrl #(
  parameter int SIZE_N   = 8,
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 1,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SIZE_N*DATA_W-1:0] vec_init,
  input  logic [DATA_W-1:0]        tol,
  output logic [SIZE_N*DATA_W-1:0] vec_to_mul,
  input  logic [SIZE_N*DATA_W-1:0] mul_result,
  output logic                     norm_start,
  output logic [SIZE_N*DATA_W-1:0] norm_in,
  input  logic                     norm_done,
  input  logic [SIZE_N*DATA_W-1:0] norm_result,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [ITER_W-1:0]        iter_count,
  output logic [SIZE_N*DATA_W-1:0] eig_vec
);

  localparam int VW     = SIZE_N * DATA_W;
  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE, MUL_WAIT, NORM_REQ, NORM_WAIT, CHECK, FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [VW-1:0]       vec_reg, prod_reg, new_reg;
  logic [DATA_W-1:0]   tol_reg;
  logic [ITER_W-1:0]   iter_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                conv_q;

  logic signed [DATA_W:0] a_ext, b_ext, diff;
  logic        [DATA_W:0] absd, maxdiff;
  logic        [ITER_W:0] iter_next;
  logic                   conv_now, last_iter, mul_cap, aborting;

  // Differences are taken one bit wider so opposite-extreme elements cannot wrap.
  always_comb begin
    a_ext   = '0;
    b_ext   = '0;
    diff    = '0;
    absd    = '0;
    maxdiff = '0;
    for (int i = 0; i < SIZE_N; i++) begin
      a_ext = {new_reg[i*DATA_W+DATA_W-1], new_reg[i*DATA_W +: DATA_W]};
      b_ext = {vec_reg[i*DATA_W+DATA_W-1], vec_reg[i*DATA_W +: DATA_W]};
      diff  = a_ext - b_ext;
      absd  = diff[DATA_W] ? -diff : diff;
      if (absd > maxdiff) maxdiff = absd;
    end
  end

  assign iter_next = {1'b0, iter_q} + (ITER_W+1)'(1);
  assign conv_now  = maxdiff <= {1'b0, tol_reg};
  assign last_iter = iter_next == (ITER_W+1)'(MAX_ITER);
  assign mul_cap   = wait_cnt == WAIT_W'(MUL_LAT - 1);
  assign aborting  = abort && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    busy       = state_q != IDLE;
    done       = state_q == FINISH;
    norm_start = state_q == NORM_REQ;
    case (state_q)
      IDLE:      if (start) state_d = MUL_WAIT;
      MUL_WAIT:  if (mul_cap) state_d = NORM_REQ;
      NORM_REQ:  state_d = NORM_WAIT;
      NORM_WAIT: if (norm_done) state_d = CHECK;
      CHECK:     state_d = (conv_now || last_iter) ? FINISH : MUL_WAIT;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (aborting) state_d = IDLE;
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vec_reg  <= '0;
      prod_reg <= '0;
      new_reg  <= '0;
      tol_reg  <= '0;
      iter_q   <= '0;
      wait_cnt <= '0;
      conv_q   <= 1'b0;
    end else if (aborting) begin
      conv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          vec_reg  <= vec_init;
          tol_reg  <= tol;
          iter_q   <= '0;
          conv_q   <= 1'b0;
          wait_cnt <= '0;
        end
        MUL_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mul_cap) prod_reg <= mul_result;
        end
        NORM_WAIT: if (norm_done) new_reg <= norm_result;
        CHECK: begin
          vec_reg <= new_reg;
          iter_q  <= iter_next[ITER_W-1:0];
          if (conv_now)        conv_q   <= 1'b1;
          else if (!last_iter) wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign vec_to_mul = vec_reg;
  assign eig_vec    = vec_reg;
  assign norm_in    = prod_reg;
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_power_iter_ctrl.sv
// Directed bench for power_iter_ctrl: two SIZE_N=2 instances (MUL_LAT=1/MAX_ITER=64 and
// MUL_LAT=3/MAX_ITER=3) with an identity multiplier and a table-or-passthrough normaliser.
module tb_power_iter_ctrl;
  localparam int DW = 32;
  localparam int VW = 2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, abort, start_a, start_b;
  logic [VW-1:0] vec_init;
  logic [DW-1:0] tol;

  logic [VW-1:0] vtm_a, nin_a, eig_a, vtm_b, nin_b, eig_b;
  logic [VW-1:0] nr_a = '0, nr_b = '0;
  logic          nd_a = 1'b0, nd_b = 1'b0;
  logic          ns_a, busy_a, done_a, conv_a, ns_b, busy_b, done_b, conv_b;
  logic [7:0]    iter_a, iter_b;

  power_iter_ctrl #(.SIZE_N(2), .DATA_W(DW), .MUL_LAT(1), .MAX_ITER(64), .ITER_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .vec_init(vec_init), .tol(tol),
    .vec_to_mul(vtm_a), .mul_result(vtm_a), .norm_start(ns_a), .norm_in(nin_a),
    .norm_done(nd_a), .norm_result(nr_a), .busy(busy_a), .done(done_a),
    .converged(conv_a), .iter_count(iter_a), .eig_vec(eig_a));

  power_iter_ctrl #(.SIZE_N(2), .DATA_W(DW), .MUL_LAT(3), .MAX_ITER(3), .ITER_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .vec_init(vec_init), .tol(tol),
    .vec_to_mul(vtm_b), .mul_result(vtm_b), .norm_start(ns_b), .norm_in(nin_b),
    .norm_done(nd_b), .norm_result(nr_b), .busy(busy_b), .done(done_b),
    .converged(conv_b), .iter_count(iter_b), .eig_vec(eig_b));

  // Normaliser models: done one cycle after norm_start; result from a table or passthrough.
  logic          use_tab_a = 1'b0, use_tab_b = 1'b0;
  logic [VW-1:0] tab_a [16];
  logic [VW-1:0] tab_b [16];
  int            idx_a = 0, idx_b = 0, ns_cnt_a = 0;

  always @(posedge clk) begin
    nd_a <= ns_a;
    if (ns_a) begin
      nr_a     <= use_tab_a ? tab_a[idx_a[3:0]] : nin_a;
      idx_a    <= idx_a + 1;
      ns_cnt_a <= ns_cnt_a + 1;
    end
    if (!rst || (start_a && !busy_a)) idx_a <= 0;
  end

  always @(posedge clk) begin
    nd_b <= ns_b;
    if (ns_b) begin
      nr_b  <= use_tab_b ? tab_b[idx_b[3:0]] : nin_b;
      idx_b <= idx_b + 1;
    end
    if (!rst || (start_b && !busy_b)) idx_b <= 0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    return {e1, e0};
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic launch(input bit sel, input logic [VW-1:0] vi, input logic [DW-1:0] t);
    vec_init = vi;
    tol      = t;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // lat counts cycles from the start edge up to and including the done cycle.
  task automatic wait_done(input bit sel, input int budget, output int lat);
    lat = 1;
    while (!(sel ? done_b : done_a) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check(sel ? "done_b_seen" : "done_a_seen", 64'(sel ? done_b : done_a), 64'd1);
  endtask

  task automatic wait_ns_a(input int budget);
    int n = 0;
    while (!ns_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("norm_start_a_seen", 64'(ns_a), 64'd1);
  endtask

  task automatic after_done(input bit sel, input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(sel ? done_b : done_a), 64'd0);
    check({tag, "_busy_low"},   64'(sel ? busy_b : busy_a), 64'd0);
  endtask

  initial begin
    int lat, ns0, seen;
    rst = 1'b0; abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
    vec_init = '0; tol = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_ns",    64'(ns_a),   64'd0);
    check("rst_conv",  64'(conv_a), 64'd0);
    check("rst_iter",  64'(iter_a), 64'd0);
    check("rst_eig",   eig_a,       64'd0);
    rst = 1'b1;

    // Passthrough normaliser: fixed point on the first iteration.
    ns0 = ns_cnt_a;
    launch(0, pk(5, 3), 32'd0);
    wait_done(0, 40, lat);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_conv",    64'(conv_a), 64'd1);
    check("t1_iter",    64'(iter_a), 64'd1);
    check("t1_eig",     eig_a, pk(5, 3));
    check("t1_nstarts", 64'(ns_cnt_a - ns0), 64'd1);
    after_done(0, "t1");
    check("t1_conv_held", 64'(conv_a), 64'd1);

    // Halving sequence converging on the fourth iteration.
    tab_a[0] = pk(4, 0); tab_a[1] = pk(2, 0); tab_a[2] = pk(1, 0); tab_a[3] = pk(1, 0);
    use_tab_a = 1'b1;
    ns0 = ns_cnt_a;
    launch(0, pk(8, 0), 32'd0);
    wait_done(0, 80, lat);
    check("t2_latency", 64'(lat), 64'd17);
    check("t2_conv",    64'(conv_a), 64'd1);
    check("t2_iter",    64'(iter_a), 64'd4);
    check("t2_eig",     eig_a, pk(1, 0));
    check("t2_nstarts", 64'(ns_cnt_a - ns0), 64'd4);
    after_done(0, "t2");

    // Iteration cap on instance b (MAX_ITER=3, MUL_LAT=3): never converges.
    tab_b[0] = pk(1, 0); tab_b[1] = pk(0, 1); tab_b[2] = pk(1, 0);
    use_tab_b = 1'b1;
    launch(1, pk(0, 1), 32'd0);
    wait_done(1, 80, lat);
    check("t3_latency", 64'(lat), 64'd19);
    check("t3_conv",    64'(conv_b), 64'd0);
    check("t3_iter",    64'(iter_b), 64'd3);
    check("t3_eig",     eig_b, pk(1, 0));
    after_done(1, "t3");

    // Extreme elements: difference 2^32-1 must not wrap.
    tab_a[0] = pk(32'h7FFF_FFFF, 0); tab_a[1] = pk(32'h7FFF_FFFF, 0);
    launch(0, pk(32'h8000_0000, 0), 32'hFFFF_FFFF);
    wait_done(0, 40, lat);
    check("t4a_conv", 64'(conv_a), 64'd1);
    check("t4a_iter", 64'(iter_a), 64'd1);
    check("t4a_eig",  eig_a, pk(32'h7FFF_FFFF, 0));
    after_done(0, "t4a");
    launch(0, pk(32'h8000_0000, 0), 32'hFFFF_FFFE);
    wait_done(0, 40, lat);
    check("t4b_conv", 64'(conv_a), 64'd1);
    check("t4b_iter", 64'(iter_a), 64'd2);
    after_done(0, "t4b");

    // Abort in NORM_WAIT of iteration 2, coinciding with norm_done.
    tab_a[0] = pk(4, 0); tab_a[1] = pk(2, 0);
    launch(0, pk(8, 0), 32'd0);
    wait_ns_a(20);
    @(negedge clk);
    wait_ns_a(20);
    @(negedge clk);
    check("t5_nd_with_abort", 64'(nd_a), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", 64'(busy_a), 64'd0);
    check("t5_done", 64'(done_a), 64'd0);
    check("t5_conv", 64'(conv_a), 64'd0);
    check("t5_iter", 64'(iter_a), 64'd1);
    check("t5_eig",  eig_a, pk(4, 0));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("t5_quiet_after_abort", 64'(seen), 64'd0);
    use_tab_a = 1'b0;
    launch(0, pk(9, 9), 32'd0);
    wait_done(0, 40, lat);
    check("t5_rerun_latency", 64'(lat), 64'd5);
    check("t5_rerun_conv",    64'(conv_a), 64'd1);
    check("t5_rerun_eig",     eig_a, pk(9, 9));
    after_done(0, "t5");

    // Start pulse during iteration 2 must be ignored.
    tab_a[0] = pk(4, 0); tab_a[1] = pk(2, 0); tab_a[2] = pk(1, 0); tab_a[3] = pk(1, 0);
    use_tab_a = 1'b1;
    launch(0, pk(8, 0), 32'd0);
    wait_ns_a(20);
    @(negedge clk);
    wait_ns_a(20);
    launch(0, pk(77, 77), 32'hFFFF_FFFF);
    wait_done(0, 80, lat);
    check("t6_conv", 64'(conv_a), 64'd1);
    check("t6_iter", 64'(iter_a), 64'd4);
    check("t6_eig",  eig_a, pk(1, 0));
    after_done(0, "t6");

    // Synchronous reset in MUL_WAIT of iteration 2 on instance b.
    tab_b[0] = pk(3, 3); tab_b[1] = pk(2, 2);
    launch(1, pk(7, 9), 32'd0);
    lat = 0;
    while (iter_b != 8'd1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t7_reached_iter2", 64'(iter_b), 64'd1);
    check("t7_busy_before",   64'(busy_b), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t7_busy", 64'(busy_b), 64'd0);
    check("t7_done", 64'(done_b), 64'd0);
    check("t7_ns",   64'(ns_b),   64'd0);
    check("t7_conv", 64'(conv_b), 64'd0);
    check("t7_iter", 64'(iter_b), 64'd0);
    check("t7_eig",  eig_b, 64'd0);
    check("t7_vtm",  vtm_b, 64'd0);
    check("t7_nin",  nin_b, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/power_iter_ctrl.md
Name: power_iter_ctrl

Overview:
Sequencer for power-iteration eigenvector extraction in the fetal ECG decomposition path. Owns the current estimate vector, drives it into the external combinational mat-vec multiplier, and hands the product to the external normaliser through a start/done handshake. Checks convergence by max element-wise difference and repeats until converged or an iteration cap is hit. Sits between the covariance (timed) matrix stage and the deflation/next-component stage.

Parameters:
SIZE_N, 8, vector length (matrix is SIZE_N x SIZE_N)
DATA_W, 32, signed element width
MUL_LAT, 1, cycles from vec_to_mul stable to mul_result valid; legal range 1..15
MAX_ITER, 64, iteration cap; legal range 1..255
ITER_W, 8, iter_count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  cancel run; returns to IDLE
vec_init  in  SIZE_N*DATA_W  initial vector; element i at bits [i*DATA_W +: DATA_W]
tol  in  DATA_W  unsigned convergence threshold; sampled with start
vec_to_mul  out  SIZE_N*DATA_W  current estimate to multiplier (= vec_reg)
mul_result  in  SIZE_N*DATA_W  multiplier product
norm_start  out  1  one-cycle request to normaliser
norm_in  out  SIZE_N*DATA_W  captured product (= prod_reg)
norm_done  in  1  normaliser result valid, single-cycle pulse
norm_result  in  SIZE_N*DATA_W  normalised vector
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run end
converged  out  1  run ended by tolerance; held until next start
iter_count  out  ITER_W  completed iterations; held until next start
eig_vec  out  SIZE_N*DATA_W  final estimate (= vec_reg)

Behaviour:
- Reset (rst==0 at posedge): state IDLE; vec_reg, prod_reg, tol_reg, iter_count, wait_cnt = 0; busy, done, norm_start, converged = 0. Reset overrides all other inputs, including mid-run.
- States: IDLE, MUL_WAIT, NORM_REQ, NORM_WAIT, CHECK, FINISH.
- IDLE: start=1 -> vec_reg<=vec_init, tol_reg<=tol, iter_count<=0, converged<=0, wait_cnt<=0, go MUL_WAIT. Start is ignored in all other states.
- MUL_WAIT: wait_cnt increments each cycle. When wait_cnt==MUL_LAT-1: prod_reg<=mul_result, go NORM_REQ. With MUL_LAT=1, capture happens on the first MUL_WAIT cycle.
- NORM_REQ: norm_start=1 for exactly this cycle, go NORM_WAIT. norm_in stays stable from NORM_REQ through NORM_WAIT.
- NORM_WAIT: on norm_done=1, new_reg<=norm_result, go CHECK. There is no timeout. A norm_done seen outside NORM_WAIT is ignored.
- CHECK (1 cycle):
  - d_i = new_reg[i] - vec_reg[i], computed at DATA_W+1 bits signed; maxdiff = max |d_i|, unsigned DATA_W+1.
  - Updates: vec_reg<=new_reg; iter_count<=iter_count+1.
  - maxdiff <= tol_reg -> converged<=1, go FINISH.
  - Else if iter_count+1 == MAX_ITER -> converged stays 0, go FINISH.
  - Else wait_cnt<=0, go MUL_WAIT.
- FINISH: done=1 for this cycle, then IDLE. busy=0 from the IDLE cycle onward.
- abort=1 in any non-IDLE state -> IDLE next cycle; done not pulsed; converged=0; vec_reg and iter_count keep their current values. If abort and norm_done arrive together, abort wins.
- Latency per iteration: MUL_LAT + 1 (NORM_REQ) + normaliser wait cycles + 1 (CHECK). Start-to-done with MUL_LAT=1 and a normaliser that returns done the cycle after norm_start: 5 cycles for one iteration.
- tol=0 requires an exact fixed point. The difference must not wrap at the most-negative/most-positive element extremes.

Test Plan:
- SIZE_N=2, MUL_LAT=1; multiplier model identity; normaliser passthrough, done one cycle after norm_start; vec_init=(5,3), tol=0 -> done 5 cycles after start, converged=1, iter_count=1, eig_vec=(5,3).
- Normaliser returns (4,0),(2,0),(1,0),(1,0); vec_init=(8,0), tol=0 -> converged=1, iter_count=4, eig_vec=(1,0); exactly 4 norm_start pulses.
- MAX_ITER=3; normaliser alternates (1,0),(0,1); tol=0 -> done after iteration 3, converged=0, iter_count=3.
- Elements 0x7FFFFFFF vs 0x80000000 (new vs old); tol=0xFFFFFFFF -> maxdiff=2^32-1 <= tol, converged=1; same case with tol=0xFFFFFFFE -> not converged.
- abort asserted in NORM_WAIT with norm_done pulsed the same cycle -> IDLE next cycle, no done pulse, busy=0, converged=0. A new start then runs normally.
- rst=0 in MUL_WAIT with MUL_LAT=3 -> all outputs 0 next cycle. A start pulse while busy (iteration 2) -> ignored; iter_count not reset.
